// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_gen
// Brief    : Fetch PC register with +4 increment and word-aligned redirect mux.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] c_STEP      = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MSK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_target;

    // Increment wraps naturally at 2^XLEN.
    assign w_pcPlus4 = r_pc + c_STEP;
    assign w_target  = redirectPc & c_ALIGN_MSK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirectValid) begin
            r_pc <= w_target;
        end else if (advance) begin
            r_pc <= w_pcPlus4;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-outstanding instruction fetch FSM between imem and decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] c_RESET_PC = RESET_PC[XLEN-1:0];

    ifu_state_t      r_state;
    ifu_state_t      w_stateNext;
    logic            r_drop;
    logic            w_dropNext;
    logic [31:0]     r_instWord;
    logic [XLEN-1:0] r_instPc;
    logic            r_instErr;
    logic [XLEN-1:0] w_pc;
    logic            w_reqFire;
    logic            w_fire;
    logic            w_capture;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (c_RESET_PC)
    ) u_pcGen (
        .clk           (clk),
        .rst           (rst),
        .advance       (w_fire),
        .redirectValid (redirect_valid),
        .redirectPc    (redirect_pc),
        .pc            (w_pc)
    );

    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = w_pc;
    assign w_reqFire      = imem_req_valid & imem_req_ready;

    // A redirect squashes the held instruction in the same cycle.
    assign inst_valid = (r_state == HOLD) & ~redirect_valid;
    assign w_fire     = inst_valid & inst_ready;
    assign w_capture  = (r_state == WAIT) & imem_rsp_valid & ~r_drop & ~redirect_valid;

    always_comb begin
        w_stateNext = r_state;
        w_dropNext  = r_drop;
        case (r_state)
            IDLE: w_stateNext = REQ;
            REQ: begin
                if (w_reqFire) begin
                    w_stateNext = WAIT;
                    if (redirect_valid) w_dropNext = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    // The owed response has arrived; whether kept or not, drop is settled.
                    w_dropNext  = 1'b0;
                    w_stateNext = (redirect_valid || r_drop) ? REQ : HOLD;
                end else if (redirect_valid) begin
                    w_dropNext = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || inst_ready) w_stateNext = REQ;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_drop  <= w_dropNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instWord <= INST_NOP;
            r_instPc   <= c_RESET_PC;
            r_instErr  <= 1'b0;
        end else if (w_capture) begin
            r_instWord <= imem_rsp_err ? INST_NOP : imem_rsp_data;
            r_instPc   <= w_pc;
            r_instErr  <= imem_rsp_err;
        end
    end

    assign inst_out = r_instWord;
    assign inst_pc  = r_instPc;
    assign inst_err = r_instErr;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Randomized scoreboard bench for ifu_fetch against a program-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [63:0] c_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ifu_fetch #(.RESET_PC(c_RESET_PC), .XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nFail   = 0;
    int   fires   = 0;
    exp_t expQ[$];

    // Stimulus knobs and imem responder state
    int          pReady, pInstReady, pRedir, maxDelay;
    bit          holdRsp, forceRsp, forceRedir, monEn;
    logic [63:0] forceTarget;
    int          acceptCnt = 0, acceptHandled = 0;
    logic [63:0] acceptAddr;
    bit          rspBusy;
    int          rspCnt;
    logic [63:0] rspAddr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction memory contents: arbitrary deterministic words, faulting at a fixed slot.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + a[63:32] + 32'h1234_5677;
    endfunction

    function automatic logic memErr(input logic [63:0] a);
        return a[6:2] == 5'd19;
    endfunction

    function automatic void pushExp(input logic [63:0] p);
        exp_t e;
        e.pc   = p;
        e.err  = memErr(p);
        e.word = e.err ? INST_NOP : memWord(p);
        expQ.push_back(e);
    endfunction

    function automatic logic [63:0] randTarget();
        logic [63:0] t;
        if ($urandom_range(0, 9) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else                           t = c_RESET_PC + 64'($urandom_range(0, 16'hFFFF));
        return t;
    endfunction

    task automatic step();
        logic [63:0] t;
        @(posedge clk);
        #1;
        if (forceRedir || (pRedir > 0 && $urandom_range(0, 99) < pRedir)) begin
            t = forceRedir ? forceTarget : randTarget();
            forceRedir     = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = t;
            expQ.delete();
            pushExp(t & ~64'h3);
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = {$urandom, $urandom};
        end
        if (expQ.size() == 0) pushExp(c_RESET_PC);
        while (expQ.size() < 4) pushExp(expQ[expQ.size()-1].pc + 64'd4);

        if (acceptHandled != acceptCnt) begin
            acceptHandled = acceptCnt;
            rspBusy       = 1'b1;
            rspAddr       = acceptAddr;
            rspCnt        = $urandom_range(0, maxDelay);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
        if (forceRsp) begin
            forceRsp       = 1'b0;
            imem_rsp_valid = 1'b1;
        end else if (rspBusy && !holdRsp) begin
            if (rspCnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(rspAddr);
                imem_rsp_err   = memErr(rspAddr);
                rspBusy        = 1'b0;
            end else begin
                rspCnt--;
            end
        end
        imem_req_ready = ($urandom_range(0, 99) < pReady);
        inst_ready     = ($urandom_range(0, 99) < pInstReady);
    endtask

    task automatic waitAccept();
        int c0 = acceptCnt;
        for (int i = 0; i < 50; i++) begin
            step();
            @(negedge clk);
            if (acceptCnt != c0) return;
        end
        nChecks++;
        nFail++;
        $display("FAIL accept_timeout: no imem request accepted within 50 cycles");
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_req_valid"},  imem_req_valid, 0);
        check({tag, "_inst_valid"}, inst_valid,     0);
        check({tag, "_inst_out"},   inst_out,       INST_NOP);
        check({tag, "_inst_pc"},    inst_pc,        c_RESET_PC);
        check({tag, "_inst_err"},   inst_err,       0);
    endtask

    // Monitor: pops the scoreboard on every decode handshake and checks stall stability.
    bit          prevReqStall, prevHoldStall;
    logic [63:0] prevAddr, prevPc;
    logic [31:0] prevWord;
    int          idle;
    exp_t        got;

    always @(negedge clk) begin
        if (rst || !monEn) begin
            prevReqStall  = 1'b0;
            prevHoldStall = 1'b0;
            idle          = 0;
        end else begin
            if (redirect_valid) check("squash_on_redirect", inst_valid, 0);
            if (prevReqStall) begin
                check("req_stall_valid", imem_req_valid, 1);
                check("req_stall_addr",  imem_req_addr,  prevAddr);
            end
            if (prevHoldStall && !redirect_valid) begin
                check("hold_valid", inst_valid,     1);
                check("hold_word",  inst_out,       prevWord);
                check("hold_pc",    inst_pc,        prevPc);
                check("hold_noreq", imem_req_valid, 0);
            end
            if (imem_req_valid) begin
                check("req_align", imem_req_addr[1:0], 0);
                if (!redirect_valid && expQ.size() > 0) check("req_addr", imem_req_addr, expQ[0].pc);
                if (imem_req_ready) begin
                    check("one_outstanding", rspBusy, 0);
                    acceptCnt++;
                    acceptAddr = imem_req_addr;
                end
            end
            if (inst_valid && inst_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL sb_underflow: got pc %h expected no instruction", inst_pc);
                end else begin
                    got = expQ.pop_front();
                    check("inst_pc",  inst_pc,  got.pc);
                    check("inst_out", inst_out, got.word);
                    check("inst_err", inst_err, got.err);
                end
                fires++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 400) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL progress: got %0d idle cycles expected at most 400", idle);
                    idle = 0;
                end
            end
            prevReqStall  = imem_req_valid && !imem_req_ready && !redirect_valid;
            prevAddr      = imem_req_addr;
            prevHoldStall = inst_valid && !inst_ready;
            prevWord      = inst_out;
            prevPc        = inst_pc;
        end
    end

    int f0;

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        pReady = 100; pInstReady = 100; pRedir = 0; maxDelay = 0;
        holdRsp = 1'b0; forceRsp = 1'b0; forceRedir = 1'b0; monEn = 1'b0;
        forceTarget = '0; rspBusy = 1'b0; rspCnt = 0; rspAddr = '0; acceptAddr = '0;

        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");

        rst = 1'b0;
        expQ.delete();
        pushExp(c_RESET_PC);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        monEn          = 1'b1;
        @(negedge clk);
        check("idle_no_req", imem_req_valid, 0);
        step();
        @(negedge clk);
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr",  imem_req_addr,  c_RESET_PC);

        // Back-to-back fetch with a 1-cycle imem
        f0 = fires;
        repeat (40) step();
        check("streaming_fires", 64'(fires - f0 >= 12), 1);

        // imem not ready for several cycles
        pReady = 0;
        repeat (5) step();
        pReady = 100;

        // Redirect while a response is owed
        holdRsp = 1'b1;
        waitAccept();
        forceRedir  = 1'b1;
        forceTarget = 64'h0000_0000_8000_1002;
        step();
        holdRsp = 1'b0;
        repeat (20) step();

        // Decode stalls in HOLD, then redirect coincides with inst_ready
        pInstReady = 0;
        for (int i = 0; i < 30 && !(inst_valid); i++) begin
            step();
            @(negedge clk);
        end
        repeat (5) step();
        forceRedir  = 1'b1;
        forceTarget = 64'h0000_0000_8000_2000;
        pInstReady  = 100;
        step();
        repeat (20) step();

        // PC wrap at the top of the address space
        forceRedir  = 1'b1;
        forceTarget = 64'hFFFF_FFFF_FFFF_FFF6;
        step();
        repeat (30) step();

        // Randomized traffic
        pReady = 70; pInstReady = 60; pRedir = 6; maxDelay = 3;
        repeat (3000) step();

        // Asynchronous reset while waiting on imem, then a stale response
        pReady = 100; pInstReady = 100; pRedir = 0; maxDelay = 0;
        holdRsp = 1'b1;
        waitAccept();
        step();
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        rspBusy       = 1'b0;
        acceptHandled = acceptCnt;
        holdRsp       = 1'b0;
        expQ.delete();
        pushExp(c_RESET_PC);
        pReady = 0;
        step();
        rst = 1'b0;
        forceRsp = 1'b1;
        step();
        forceRsp = 1'b1;
        step();
        pReady = 100;
        f0 = fires;
        repeat (30) step();
        check("post_reset_fires", 64'(fires - f0 >= 8), 1);

        check("total_progress", 64'(fires >= 300), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
